// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared multicycle RISC-V datapath (one memory port, one ALU).
// Drives every datapath mux/enable, stalls on mem_ready and counts retired instructions.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE   | read registers, compute branch target into ALUOut
// MEMADR   | compute load/store effective address
// MEMREAD  | load data access, waits for mem_ready
// MEMWB    | write loaded data to rd
// MEMWRITE | store data access, waits for mem_ready
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALUOut to rd
// JAL      | PC <= target, ALUOut <= OldPC+4
// BEQ      | compare, take branch on zero
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic             reg_write,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state_q, state_d;
  logic   pc_write_c, ir_write_c, mem_write_c, reg_write_c, done_c, illegal_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    done_c      = 1'b0;
    illegal_c   = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXECR;
          OP_ITYP:      state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            illegal_c = 1'b1;
            done_c    = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        done_c      = mem_ready;
        state_d     = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write_c = zero;
        done_c     = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // State already reads FETCH in reset; the enables must also be held off.
  assign pc_write   = pc_write_c  & rst_n;
  assign ir_write   = ir_write_c  & rst_n;
  assign mem_write  = mem_write_c & rst_n;
  assign reg_write  = reg_write_c & rst_n;
  assign instr_done = done_c      & rst_n;
  assign illegal_op = illegal_c   & rst_n;
  assign state      = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instr_count <= '0;
    else if (instr_done) instr_count <= instr_count + 1'b1;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences the shared multicycle RISC-V datapath: one memory port, one ALU, and the IR/PC/ALUOut registers.
- Steps each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath mux and enable.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Adds a memory-ready stall handshake and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_count

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  7  instr[6:0] from the IR (valid from DECODE onward)
zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  PC register enable
adr_src  output  1  memory address select: 0=PC, 1=ALUOut
mem_write  output  1  data memory write strobe
ir_write  output  1  IR/OldPC enable
result_src  output  2  result mux select: 00=ALUOut, 01=MemData, 10=ALUResult
alu_src_a  output  2  ALU A select: 00=PC, 01=OldPC, 10=RD1
alu_src_b  output  2  ALU B select: 00=RD2, 01=ImmExt, 10=const 4
alu_op  output  2  to ALU decoder: 00=add, 01=sub, 10=funct-decoded
imm_src  output  2  immediate format select
reg_write  output  1  register file write enable
illegal_op  output  1  unsupported opcode seen in DECODE
instr_done  output  1  one-cycle pulse on instruction retirement
instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W
state  output  4  current state, for debug

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: state=FETCH (0) and instr_count=0.
  - While rst_n=0, pc_write, ir_write, reg_write, mem_write, instr_done and illegal_op are forced to 0.
  - All other outputs take their FETCH values.
- Outputs are a combinational function of state. Exceptions: mem_ready gating, zero for pc_write, opcode for imm_src/illegal_op.
- Outputs not listed for a state are 0.
- imm_src decodes from opcode in every state: 0000011→00, 0010011→00, 0100011→01, 1100011→10, 1101111→11, others→00.
- State encoding and per-state actions:
  - FETCH=0: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
    - ir_write=mem_ready, pc_write=mem_ready.
    - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE=1: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut).
    - Next state by opcode: lw or sw→MEMADR; 0110011→EXECR; 0010011→EXECI; 1101111→JAL; 1100011→BEQ.
    - Any other opcode: illegal_op=1, instr_done=1, next state FETCH.
  - MEMADR=2: alu_src_a=10, alu_src_b=01, alu_op=00. Next state MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD=3: adr_src=1. Holds until mem_ready=1, then goes to MEMWB.
  - MEMWB=4: result_src=01, reg_write=1, instr_done=1. Next state FETCH.
  - MEMWRITE=5: adr_src=1, mem_write=1, held asserted until mem_ready=1.
    - On the cycle with mem_ready=1: instr_done=1, next state FETCH.
  - EXECR=6: alu_src_a=10, alu_src_b=00, alu_op=10. Next state ALUWB.
  - EXECI=7: alu_src_a=10, alu_src_b=01, alu_op=10. Next state ALUWB.
  - ALUWB=8: result_src=00, reg_write=1, instr_done=1. Next state FETCH.
  - JAL=9: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next state ALUWB (writes PC+4 to rd).
  - BEQ=10: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
    - pc_write=zero, instr_done=1. Next state FETCH.
- Encodings 11–15 are unreachable. If entered, the FSM goes to FETCH next cycle with all enables 0.
- instr_count increments by 1 on every clk edge where instr_done=1 and rst_n=1. All-ones wraps to 0.
- Instruction latency with mem_ready always 1:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
  - illegal opcode: 2 cycles.
- Each memory-ready stall cycle adds 1 cycle.
- Reset asserted mid-instruction: state goes to FETCH immediately and the partial instruction is discarded (not counted).
- opcode is sampled only in DECODE and MEMADR. The IR is stable then because ir_write is only asserted in FETCH.

Test Plan:
- Reset release with mem_ready=1 and opcode=0110011 → states 0,1,6,8,0; reg_write=1 only in ALUWB; instr_done pulses once; instr_count=1.
- lw (0000011) with mem_ready=0 for 3 cycles in MEMREAD → state stays 3 for 3 cycles; adr_src=1 throughout; MEMWB follows; total 8 cycles; result_src=01 in MEMWB.
- sw (0100011) with mem_ready low 2 cycles in MEMWRITE → mem_write=1 for exactly 3 cycles; reg_write never 1; instr_done on the final cycle only.
- beq (1100011) run twice, once with zero=1 and once with zero=0 → pc_write=1 in BEQ only when zero=1; alu_op=01; imm_src=10 in DECODE.
- jal (1101111) → pc_write=1 in FETCH and in JAL; result_src=00 with reg_write=1 in ALUWB; imm_src=11.
- Opcode 1111111 → illegal_op=1 for one DECODE cycle; return to FETCH; count +1. Separately, rst_n pulled low in MEMREAD → state=0 asynchronously and count unchanged. With CNT_W=4, 16 retirements → instr_count wraps to 0.
